// File: rtl/softsign_pkg.sv
// rtl/softsign_pkg.sv - shared constants and state encoding for the softsign datapath
//
// Purpose: constants shared by the denominator, divider and neuron blocks.
//   SOFTSIGN_FRAC : default fraction bits of the softsign result
//   DATA_W        : operand / result width
//   state_e       : divider FSM encoding (S_IDLE, S_DIV, S_FIN)
package softsign_pkg;

    localparam int SOFTSIGN_FRAC = 16;
    localparam int DATA_W        = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/softsign_divider.sv
// rtl/softsign_divider.sv - restoring divider computing Y = X / (1 + |X|)
//
// Purpose: accepts X and denom on a start pulse, runs FRAC restoring
// iterations and returns the signed fixed-point quotient with a done pulse.
// Ports:
//   CLOCK  in  : rising-edge clock
//   reset  in  : asynchronous active-low reset
//   X      in  : two's-complement numerator, captured on start
//   denom  in  : unsigned denominator, captured on start
//   start  in  : request qualifier, honoured only in IDLE
//   busy   out : high from the start edge through the done cycle
//   done   out : one-cycle pulse, Y/ovf valid from this cycle on
//   Y      out : signed result with FRAC fraction bits
//   ovf    out : |X| >= denom or denom == 0; Y saturated
module softsign_divider
    import softsign_pkg::*;
#(
    parameter int FRAC = SOFTSIGN_FRAC
) (
    input  logic              CLOCK,
    input  logic              reset,
    input  logic [DATA_W-1:0] X,
    input  logic [DATA_W-1:0] denom,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] Y,
    output logic              ovf
);

    localparam int K_W = $clog2(FRAC + 1);
    localparam logic [DATA_W-1:0] MAG_MAX = (DATA_W'(1) << FRAC) - DATA_W'(1);

    state_e            state_q, state_d;
    logic              sgn_q, sgn_d;
    logic              ovf_n_q, ovf_n_d;
    logic [DATA_W:0]   r_q, r_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic [K_W-1:0]    k_q, k_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] y_q, y_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] abs_x;
    logic [DATA_W+1:0] t;
    logic              t_ge;
    logic [DATA_W-1:0] mag;

    // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
    assign abs_x = X[DATA_W-1] ? (~X + DATA_W'(1)) : X;

    assign t    = {r_q, 1'b0};
    assign t_ge = (t >= {2'b00, d_q});
    assign mag  = ovf_n_q ? MAG_MAX : q_q;

    always_comb begin
        state_d = state_q;
        sgn_d   = sgn_q;
        ovf_n_d = ovf_n_q;
        r_d     = r_q;
        d_d     = d_q;
        q_d     = q_q;
        k_d     = k_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        y_d     = y_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    sgn_d   = X[DATA_W-1];
                    d_d     = denom;
                    ovf_n_d = (denom == '0) || (abs_x >= denom);
                    r_d     = {1'b0, abs_x};
                    q_d     = '0;
                    k_d     = K_W'(FRAC);
                    busy_d  = 1'b1;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                // Iterations still run on overflow; FIN discards the quotient.
                // Only the low DATA_W+1 bits of t - d matter since r < d normally.
                r_d = t_ge ? (t[DATA_W:0] - {1'b0, d_q}) : t[DATA_W:0];
                q_d = {q_q[DATA_W-2:0], t_ge};
                k_d = k_q - K_W'(1);
                if (k_q == K_W'(1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                y_d     = sgn_q ? (DATA_W'(0) - mag) : mag;
                ovf_d   = ovf_n_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sgn_q   <= 1'b0;
            ovf_n_q <= 1'b0;
            r_q     <= '0;
            d_q     <= '0;
            q_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sgn_q   <= sgn_d;
            ovf_n_q <= ovf_n_d;
            r_q     <= r_d;
            d_q     <= d_d;
            q_q     <= q_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Y    = y_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_softsign_divider.sv
// tb/tb_softsign_divider.sv - directed self-checking bench for softsign_divider
module tb_softsign_divider;

    logic        CLOCK;
    logic        reset;
    logic [31:0] X;
    logic [31:0] denom;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] Y;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    softsign_divider #(.FRAC(16)) dut (
        .CLOCK (CLOCK),
        .reset (reset),
        .X     (X),
        .denom (denom),
        .start (start),
        .busy  (busy),
        .done  (done),
        .Y     (Y),
        .ovf   (ovf)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] d,
                          input logic [31:0] ey, input logic eovf, input bit tail);
        int n;
        @(negedge CLOCK);
        start = 1'b1;
        X     = x;
        denom = d;
        @(posedge CLOCK);
        #1;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        @(negedge CLOCK);
        start = 1'b0;
        X     = $urandom;
        denom = $urandom;
        n = 0;
        do begin
            @(posedge CLOCK);
            n++;
            #1;
        end while (!done && n < 40);
        check({tag, "_latency"}, 32'(n), 32'd17);
        check({tag, "_Y"}, Y, ey);
        check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
        if (tail) begin
            @(posedge CLOCK);
            #1;
            check({tag, "_done_fall"}, 32'(done), 32'd0);
            check({tag, "_busy_fall"}, 32'(busy), 32'd0);
            check({tag, "_Y_hold"}, Y, ey);
        end
    endtask

    initial begin
        int dc;
        reset = 1'b0;
        start = 1'b0;
        X     = '0;
        denom = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_Y", Y, 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge CLOCK);
        reset = 1'b1;

        run_op("pos_3_4",   32'd3,          32'd4,          32'h0000C000, 1'b0, 1'b1);
        run_op("neg_3_4",   32'hFFFFFFFD,   32'd4,          32'hFFFF4000, 1'b0, 1'b1);
        run_op("zero",      32'd0,          32'd1,          32'h00000000, 1'b0, 1'b1);
        run_op("max_pos",   32'h7FFFFFFF,   32'h80000000,   32'h0000FFFF, 1'b0, 1'b1);
        run_op("min_neg",   32'h80000000,   32'h80000001,   32'hFFFF0001, 1'b0, 1'b1);
        run_op("ovf_eq",    32'd5,          32'd5,          32'h0000FFFF, 1'b1, 1'b1);
        run_op("ovf_dzero", 32'hFFFFFFF9,   32'd0,          32'hFFFF0001, 1'b1, 1'b1);

        // Extra start pulses at cycle 3 (DIV) and 17 (FIN) must be ignored.
        @(negedge CLOCK);
        start = 1'b1;
        X     = 32'd3;
        denom = 32'd4;
        @(posedge CLOCK);
        dc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLOCK);
            start = (c == 3 || c == 17);
            X     = 32'd1;
            denom = 32'd2;
            @(posedge CLOCK);
            #1;
            if (done) begin
                dc++;
                check("ign_done_cycle", 32'(c), 32'd17);
            end
        end
        check("ign_done_count", 32'(dc), 32'd1);
        check("ign_Y", Y, 32'h0000C000);
        check("ign_busy_end", 32'(busy), 32'd0);

        // Back-to-back: second start in the cycle right after done.
        run_op("b2b_first",  32'd1,        32'd4, 32'h00004000, 1'b0, 1'b0);
        run_op("b2b_second", 32'hFFFFFFFF, 32'd2, 32'hFFFF8000, 1'b0, 1'b1);

        // Asynchronous reset during iteration 8.
        @(negedge CLOCK);
        start = 1'b1;
        X     = 32'd3;
        denom = 32'd4;
        @(posedge CLOCK);
        @(negedge CLOCK);
        start = 1'b0;
        repeat (8) @(posedge CLOCK);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_Y", Y, 32'd0);
        dc = 0;
        repeat (3) begin
            @(posedge CLOCK);
            #1;
            dc += int'(done);
        end
        @(negedge CLOCK);
        reset = 1'b1;
        repeat (25) begin
            @(posedge CLOCK);
            #1;
            dc += int'(done);
        end
        check("arst_no_done", 32'(dc), 32'd0);
        check("arst_idle_busy", 32'(busy), 32'd0);
        run_op("post_rst", 32'd1, 32'd2, 32'h00008000, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/softsign_divider.md
# softsign_divider

Consumer end of the softsign datapath's denominator handshake. It accepts the pulse-qualified denominator `denom = 1 + |X|` together with the original `X` and computes the signed fixed-point softsign `Y = X / denom` using a radix-2 restoring divider. It returns the result with a one-cycle `done` pulse and sits between the denominator stage and the neuron output register.

## Interface
- `FRAC`, 16: fraction bits of `Y`; also the number of divide iterations; legal range 1..30.
- `CLOCK` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `X` in 32: two's-complement numerator; captured when `start` is sampled.
- `denom` in 32: unsigned denominator; captured when `start` is sampled.
- `start` in 1: request qualifier, driven by the denominator stage's `startout`.
- `busy` out 1: high while a division is in progress, including the done cycle.
- `done` out 1: one-cycle pulse; `Y` and `ovf` are valid from this cycle on.
- `Y` out 32: two's-complement result with `FRAC` fraction bits, sign-extended.
- `ovf` out 1: set when `|X| >= denom` or `denom == 0`; `Y` is saturated.

## Operation
- The state machine has three states: IDLE, DIV and FIN.
- **IDLE**
  - On `start == 1`, capture `sgn = X[31]`, `a = |X|` as 32-bit unsigned (0x80000000 maps to 2^31) and `d = denom`.
  - Set `ovf_n = (d == 0) || (a >= d)`.
  - Load the 33-bit remainder `r = a`, clear the quotient `q`, load the iteration counter `k = FRAC`, then go to DIV.
  - If `start == 0`, stay in IDLE.
- **DIV**, one iteration per cycle:
  - `t = {r, 1'b0}`.
  - If `t >= d`: `r = t - d` and shift a 1 into `q`; otherwise `r = t` and shift a 0 into `q`.
  - Decrement `k`. The last iteration occurs at `k == 1`, then go to FIN.
  - If `ovf_n` is set, run the iterations anyway; their result is discarded.
- **FIN**, lasting one cycle:
  - Compute `mag = ovf_n ? 2^FRAC - 1 : q`.
  - Register `Y = sgn ? -mag : mag`, register `ovf = ovf_n`, pulse `done`, then return to IDLE.
- Because `|X| < 1 + |X|`, the quotient is below 2^FRAC, so `FRAC` iterations are exact. The result truncates toward zero in magnitude.
- `Y` and `ovf` hold their values until the next FIN.
- `start` is ignored in DIV and FIN. A request arriving in the FIN cycle is dropped; upstream must not issue one.

## Timing
- Reset values: `busy = 0`, `done = 0`, `Y = 0`, `ovf = 0`, state = IDLE, and all internal registers cleared.
- Let edge 0 be the edge that samples `start`.
  - Edges 1..FRAC perform the iterations.
  - Edge FRAC+1 registers `Y` and `ovf` and raises `done`.
  - Edge FRAC+2 clears `done` and `busy`.
- Latency from the start edge to `done` high is FRAC+1 cycles; throughput is one result per FRAC+2 cycles.
- `busy` rises at edge 0 and falls at edge FRAC+2.
- A new `start` is accepted no earlier than edge FRAC+2, i.e. `start` may be high in the cycle after `done`.
- `X` and `denom` need only be valid in the cycle `start` is high. Both operands are captured internally, so upstream may change them afterwards.
- Reset asserted mid-division aborts the operation immediately: no `done` pulse, `Y` returns to 0, and the block is ready in IDLE on the first edge after release.
- Simultaneous `start` with reset deassertion: `start` is sampled on the first edge at which `reset` is already high.

## Structure
- Shared package `softsign_pkg`:
  - `SOFTSIGN_FRAC` default (16), reused by the denominator and neuron blocks.
  - State encoding constants `S_IDLE`, `S_DIV`, `S_FIN`.
  - The width constant `DATA_W = 32`.
- Single flat module. No sub-module is needed: the restoring step is one compare/subtract and stays inline.

## Test plan
- `FRAC = 16`, `X = 3`, `denom = 4`, one-cycle `start` -> `done` 17 cycles after the start edge, `Y = 0x0000C000`, `ovf = 0`.
- `X = 0xFFFFFFFD` (-3), `denom = 4` -> `Y = 0xFFFF4000`. Also `X = 0`, `denom = 1` -> `Y = 0x00000000`.
- Extremes:
  - `X = 0x7FFFFFFF`, `denom = 0x80000000` -> `Y = 0x0000FFFF`.
  - `X = 0x80000000`, `denom = 0x80000001` -> `Y = 0xFFFF0001`.
- Overflow:
  - `X = 5`, `denom = 5` -> `ovf = 1`, `Y = 0x0000FFFF`.
  - `X = -7`, `denom = 0` -> `ovf = 1`, `Y = 0xFFFF0001`.
- Pulse `start` again at cycles 3 and 17 after an accepted start -> both ignored, exactly one `done`. A back-to-back `start` in the cycle after `done` -> accepted, and the second result is correct.
- Assert `reset` low at iteration 8 -> `busy`, `done` and `Y` go to 0 asynchronously and no `done` follows. After release, a fresh `X = 1`, `denom = 2` -> `Y = 0x00008000`.
